// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready operand and result bundle for pipelined_barrel_shifter.
// out_zero/out_carry exist only when BSHIFT_STATUS_EN is defined.
interface pipelined_barrel_shifter_if #(parameter int WIDTH = 32);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
`ifdef BSHIFT_STATUS_EN
   logic             out_zero;
   logic             out_carry;
`endif

   modport master (
      output in_valid, in_data, in_shamt, in_op, out_ready,
      input  in_ready, out_valid, out_data
`ifdef BSHIFT_STATUS_EN
      , out_zero, out_carry
`endif
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_op, out_ready,
      output in_ready, out_valid, out_data
`ifdef BSHIFT_STATUS_EN
      , out_zero, out_carry
`endif
   );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROL barrel shifter, one register stage per shift level.
// Optional status outputs (out_zero, out_carry) are enabled by BSHIFT_STATUS_EN.
module bshift_slice #(
   parameter int WIDTH = 32,
   parameter int K     = 0
) (
   input  logic [WIDTH-1:0] din,
   input  logic [1:0]       op,
   input  logic             en,
`ifdef BSHIFT_STATUS_EN
   input  logic             cin,
   output logic             cout,
`endif
   output logic [WIDTH-1:0] dout
);
   localparam int S = 2**K;

   logic [WIDTH-1:0] shifted;

   // SRA refills with the current MSB, which every earlier stage has preserved as the original sign
   always_comb begin
      shifted = din;
      unique case (op)
         2'b00:   shifted = din << S;
         2'b01:   shifted = din >> S;
         2'b10:   shifted = WIDTH'($signed(din) >>> S);
         default: shifted = (din << S) | (din >> (WIDTH - S));
      endcase
   end

   assign dout = en ? shifted : din;

`ifdef BSHIFT_STATUS_EN
   // the last bit leaving this stage lands at A[WIDTH-shamt] / A[shamt-1] once all stages compose
   assign cout = !en ? cin : (op[0] ^ op[1]) ? din[S-1] : din[WIDTH-S];
`endif
endmodule

module pipelined_barrel_shifter #(
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   pipelined_barrel_shifter_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);

   logic                      adv;
   logic [SHW-1:0]            vld_pipe;
   logic [SHW-1:0][WIDTH-1:0] data_q, data_nx;
   logic [SHW-1:0][SHW-1:0]   shamt_q;
   logic [SHW-1:0][1:0]       op_q;
`ifdef BSHIFT_STATUS_EN
   logic [SHW-1:0]            cy_q, cy_nx;
   logic                      zero_q;
`endif

   assign adv          = !vld_pipe[SHW-1] | bus.out_ready;
   assign bus.in_ready = adv;

   for (genvar k = 0; k < SHW; k++) begin : g_stg
      logic [WIDTH-1:0] s_din;
      logic [1:0]       s_op;
      logic             s_en;
`ifdef BSHIFT_STATUS_EN
      logic             s_cin;
`endif
      if (k == 0) begin : g_head
         assign s_din = bus.in_data;
         assign s_op  = bus.in_op;
         assign s_en  = bus.in_shamt[0];
`ifdef BSHIFT_STATUS_EN
         assign s_cin = 1'b0;
`endif
      end else begin : g_body
         assign s_din = data_q[k-1];
         assign s_op  = op_q[k-1];
         assign s_en  = shamt_q[k-1][k];
`ifdef BSHIFT_STATUS_EN
         assign s_cin = cy_q[k-1];
`endif
      end

      bshift_slice #(.WIDTH(WIDTH), .K(k)) u_slice (
         .din  (s_din),
         .op   (s_op),
         .en   (s_en),
`ifdef BSHIFT_STATUS_EN
         .cin  (s_cin),
         .cout (cy_nx[k]),
`endif
         .dout (data_nx[k])
      );
   end

   // whole pipe advances together; a stalled output freezes every stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         data_q   <= '0;
         shamt_q  <= '0;
         op_q     <= '0;
`ifdef BSHIFT_STATUS_EN
         cy_q     <= '0;
         zero_q   <= 1'b0;
`endif
      end else if (adv) begin
         vld_pipe <= {vld_pipe[SHW-2:0], bus.in_valid};
         shamt_q  <= {shamt_q[SHW-2:0], bus.in_shamt};
         op_q     <= {op_q[SHW-2:0], bus.in_op};
         data_q   <= data_nx;
`ifdef BSHIFT_STATUS_EN
         cy_q     <= cy_nx;
         zero_q   <= (data_nx[SHW-1] == '0);
`endif
      end
   end

   assign bus.out_valid = vld_pipe[SHW-1];
   assign bus.out_data  = data_q[SHW-1];
`ifdef BSHIFT_STATUS_EN
   assign bus.out_zero  = zero_q;
   assign bus.out_carry = cy_q[SHW-1];
`endif

   // lower shamt bits and the final stage's control are carried but not consumed downstream
   logic unused_ctrl;
   assign unused_ctrl = ^{shamt_q, op_q};
endmodule
